// File: rtl/param_reg_file_if.sv
// rtl/param_reg_file_if.sv - register-file bus: C/A/B ports, clear select and data-memory handshake
interface param_reg_file_if #(
    parameter int DATA_W = 19,
    parameter int MEM_W  = 8,
    parameter int SEL_W  = 4
);
    logic [SEL_W-1:0]  clr_sel;
    logic [SEL_W-1:0]  c_sel;
    logic [DATA_W-1:0] c_in;
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  b_sel;
    logic [1:0]        mem_op;
    logic              mem_ack;
    logic [MEM_W-1:0]  mem_rdata;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [DATA_W-1:0] dm_addr;
    logic [MEM_W-1:0]  dm_wdata;
    logic              dm_rd;
    logic              dm_wr;
    logic              busy;

    modport master (
        output clr_sel, c_sel, c_in, a_sel, b_sel, mem_op, mem_ack, mem_rdata,
        input  a_out, b_out, dm_addr, dm_wdata, dm_rd, dm_wr, busy
    );

    modport slave (
        input  clr_sel, c_sel, c_in, a_sel, b_sel, mem_op, mem_ack, mem_rdata,
        output a_out, b_out, dm_addr, dm_wdata, dm_rd, dm_wr, busy
    );
endinterface

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - parameterised register file with DMAR/DMDR data-memory access FSM
module param_reg_file #(
    parameter int DATA_W   = 19,
    parameter int MEM_W    = 8,
    parameter int NUM_REGS = 14,
    parameter int SEL_W    = 4,
    parameter int BYPASS   = 0,
    parameter int ADDR_INC = 0
) (
    input  logic               clk,
    input  logic               RST,
    param_reg_file_if.slave    bus
);
    localparam int DMAR = 0;
    localparam int DMDR = 1;

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t            state_q;
    logic              dm_rd_q;
    logic              dm_wr_q;
    logic              busy_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              done;
    logic              load_done;
    logic              c_valid;
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;

    assign done      = bus.mem_ack && (state_q != IDLE);
    assign load_done = bus.mem_ack && (state_q == LOAD);

    // Later assignments win: C-bus, then auto-increment, then load, then clear.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.c_sel == SEL_W'(i + 1)) regs_d[i] = bus.c_in;
        end
        if ((ADDR_INC != 0) && done) regs_d[DMAR] = regs_q[DMAR] + DATA_W'(1);
        if (load_done) regs_d[DMDR] = DATA_W'(bus.mem_rdata);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.clr_sel == SEL_W'(i + 1)) regs_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            dm_rd_q <= 1'b0;
            dm_wr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_op == 2'b10) begin
                        state_q <= LOAD;
                        dm_rd_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (bus.mem_op == 2'b01) begin
                        state_q <= STORE;
                        dm_wr_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.mem_ack) begin
                        state_q <= IDLE;
                        dm_rd_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                STORE: begin
                    if (bus.mem_ack) begin
                        state_q <= IDLE;
                        dm_wr_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dm_rd_q <= 1'b0;
                    dm_wr_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding only applies to a C select that actually names a register.
    always_comb begin
        a_rd    = '0;
        b_rd    = '0;
        c_valid = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.a_sel == SEL_W'(i + 1)) a_rd = regs_q[i];
            if (bus.b_sel == SEL_W'(i + 1)) b_rd = regs_q[i];
            if (bus.c_sel == SEL_W'(i + 1)) c_valid = 1'b1;
        end
        if ((BYPASS != 0) && c_valid && (bus.c_sel == bus.a_sel)) a_rd = bus.c_in;
        if ((BYPASS != 0) && c_valid && (bus.c_sel == bus.b_sel)) b_rd = bus.c_in;
    end

    assign bus.a_out    = a_rd;
    assign bus.b_out    = b_rd;
    assign bus.dm_addr  = regs_q[DMAR];
    assign bus.dm_wdata = regs_q[DMDR][MEM_W-1:0];
    assign bus.dm_rd    = dm_rd_q;
    assign bus.dm_wr    = dm_wr_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - directed bench for param_reg_file (plain and bypass/auto-increment builds)
module tb_param_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  clr_sel, c_sel, a_sel, b_sel;
    logic [18:0] c_in;
    logic [1:0]  mem_op;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_reg_file_if #(.DATA_W(19), .MEM_W(8), .SEL_W(4)) if0 ();
    param_reg_file_if #(.DATA_W(19), .MEM_W(8), .SEL_W(4)) if1 ();

    assign if0.clr_sel = clr_sel;  assign if1.clr_sel = clr_sel;
    assign if0.c_sel = c_sel;      assign if1.c_sel = c_sel;
    assign if0.c_in = c_in;        assign if1.c_in = c_in;
    assign if0.a_sel = a_sel;      assign if1.a_sel = a_sel;
    assign if0.b_sel = b_sel;      assign if1.b_sel = b_sel;
    assign if0.mem_op = mem_op;    assign if1.mem_op = mem_op;
    assign if0.mem_ack = mem_ack;  assign if1.mem_ack = mem_ack;
    assign if0.mem_rdata = mem_rdata; assign if1.mem_rdata = mem_rdata;

    param_reg_file #(.BYPASS(0), .ADDR_INC(0)) u0 (.clk(clk), .RST(rst), .bus(if0.slave));
    param_reg_file #(.BYPASS(1), .ADDR_INC(1)) u1 (.clk(clk), .RST(rst), .bus(if1.slave));

    task automatic clear_inputs();
        clr_sel = 0; c_sel = 0; a_sel = 0; b_sel = 0;
        c_in = 0; mem_op = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        a_sel = 1; b_sel = 2;
        #1;
        n_checks++;
        if ({if0.busy, if0.dm_rd, if0.dm_wr, if1.busy, if1.dm_rd, if1.dm_wr} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b%b%b %b%b%b want 000 000", if0.busy, if0.dm_rd, if0.dm_wr, if1.busy, if1.dm_rd, if1.dm_wr);
        end
        n_checks++;
        if ({if0.dm_addr, if1.dm_addr} !== 38'h0) begin
            n_errors++;
            $display("FAIL reset_dm_addr: got %h %h want 0", if0.dm_addr, if1.dm_addr);
        end
        n_checks++;
        if ({if0.dm_wdata, if1.dm_wdata} !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_dm_wdata: got %h %h want 0", if0.dm_wdata, if1.dm_wdata);
        end
        n_checks++;
        if ({if0.a_out, if0.b_out, if1.a_out, if1.b_out} !== 76'h0) begin
            n_errors++;
            $display("FAIL reset_reads: got %h %h %h %h want 0", if0.a_out, if0.b_out, if1.a_out, if1.b_out);
        end
        clear_inputs();
    endtask

    task automatic test_read_write();
        logic [18:0] exp;
        c_sel = 3; c_in = 19'h5A5A5; a_sel = 3;
        #1;
        n_checks++;
        if (if0.a_out !== 19'h0) begin
            n_errors++;
            $display("FAIL nobypass_same_cycle: got %h want 00000", if0.a_out);
        end
        n_checks++;
        if (if1.a_out !== 19'h5A5A5) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: got %h want 5a5a5", if1.a_out);
        end
        cyc();
        a_sel = 3; b_sel = 0;
        #1;
        n_checks++;
        if ({if0.a_out, if0.b_out, if1.a_out} !== {19'h5A5A5, 19'h0, 19'h5A5A5}) begin
            n_errors++;
            $display("FAIL r0_read: got %h %h %h want 5a5a5 00000 5a5a5", if0.a_out, if0.b_out, if1.a_out);
        end
        c_sel = 15; clr_sel = 15; c_in = 19'h7FFFF;
        cyc();
        for (int s = 1; s <= 15; s++) begin
            a_sel = 4'(s);
            #1;
            exp = (s == 3) ? 19'h5A5A5 : 19'h0;
            n_checks++;
            if (if0.a_out !== exp) begin
                n_errors++;
                $display("FAIL out_of_range_sel%0d: got %h want %h", s, if0.a_out, exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load();
        c_sel = 1; c_in = 19'h00010;
        cyc();
        mem_op = 2'b10;
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({if0.dm_rd, if0.busy, if0.dm_wr, if1.dm_rd} !== 4'b1101) begin
                n_errors++;
                $display("FAIL load_wait%0d: got rd=%b busy=%b wr=%b rd1=%b want 1 1 0 1", k, if0.dm_rd, if0.busy, if0.dm_wr, if1.dm_rd);
            end
            if (k == 2) begin mem_ack = 1; mem_rdata = 8'hC3; end
            cyc();
        end
        a_sel = 2;
        #1;
        n_checks++;
        if ({if0.busy, if0.dm_rd, if1.busy, if1.dm_rd} !== 4'b0) begin
            n_errors++;
            $display("FAIL load_done_flags: got %b%b %b%b want 00 00", if0.busy, if0.dm_rd, if1.busy, if1.dm_rd);
        end
        n_checks++;
        if ({if0.a_out, if1.a_out, if0.dm_wdata} !== {19'h000C3, 19'h000C3, 8'hC3}) begin
            n_errors++;
            $display("FAIL load_dmdr: got %h %h %h want 000c3 000c3 c3", if0.a_out, if1.a_out, if0.dm_wdata);
        end
        n_checks++;
        if ({if0.dm_addr, if1.dm_addr} !== {19'h00010, 19'h00011}) begin
            n_errors++;
            $display("FAIL load_dmar: got %h %h want 00010 00011", if0.dm_addr, if1.dm_addr);
        end
        clear_inputs();
    endtask

    task automatic test_store_wrap();
        c_sel = 1; c_in = 19'h7FFFF;
        cyc();
        mem_op = 2'b01;
        cyc();
        n_checks++;
        if ({if0.dm_wr, if0.dm_rd, if1.dm_wr, if0.dm_wdata, if1.dm_wdata} !== {3'b101, 8'hC3, 8'hC3}) begin
            n_errors++;
            $display("FAIL store_active: got wr=%b rd=%b wr1=%b wd=%h %h want 1 0 1 c3 c3", if0.dm_wr, if0.dm_rd, if1.dm_wr, if0.dm_wdata, if1.dm_wdata);
        end
        mem_ack = 1;
        cyc();
        a_sel = 2;
        #1;
        n_checks++;
        if ({if0.dm_addr, if1.dm_addr} !== {19'h7FFFF, 19'h00000}) begin
            n_errors++;
            $display("FAIL store_wrap_dmar: got %h %h want 7ffff 00000", if0.dm_addr, if1.dm_addr);
        end
        n_checks++;
        if ({if0.dm_wr, if0.busy, if1.dm_wr, if1.busy} !== 4'b0) begin
            n_errors++;
            $display("FAIL store_done_flags: got %b%b %b%b want 00 00", if0.dm_wr, if0.busy, if1.dm_wr, if1.busy);
        end
        n_checks++;
        if ({if0.a_out, if1.a_out} !== {19'h000C3, 19'h000C3}) begin
            n_errors++;
            $display("FAIL store_dmdr_kept: got %h %h want 000c3 000c3", if0.a_out, if1.a_out);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        mem_op = 2'b10;
        cyc();
        clr_sel = 2; c_sel = 2; c_in = 19'h01234; mem_ack = 1; mem_rdata = 8'h55;
        cyc();
        a_sel = 2;
        #1;
        n_checks++;
        if ({if0.a_out, if1.a_out, if0.busy, if1.busy} !== {38'h0, 2'b00}) begin
            n_errors++;
            $display("FAIL clear_beats_load: got %h %h busy %b%b want 0 0 busy 00", if0.a_out, if1.a_out, if0.busy, if1.busy);
        end
        clear_inputs();
        mem_op = 2'b10;
        cyc();
        c_sel = 2; c_in = 19'h03333; mem_ack = 1; mem_rdata = 8'h5A;
        cyc();
        a_sel = 2;
        #1;
        n_checks++;
        if ({if0.a_out, if1.a_out} !== {19'h0005A, 19'h0005A}) begin
            n_errors++;
            $display("FAIL load_beats_cbus: got %h %h want 0005a 0005a", if0.a_out, if1.a_out);
        end
        clear_inputs();
        mem_op = 2'b10;
        cyc();
        c_sel = 1; c_in = 19'h00100; mem_ack = 1; mem_rdata = 8'h01;
        cyc();
        n_checks++;
        if ({if0.dm_addr, if1.dm_addr} !== {19'h00100, 19'h00003}) begin
            n_errors++;
            $display("FAIL inc_beats_cbus: got %h %h want 00100 00003", if0.dm_addr, if1.dm_addr);
        end
        c_sel = 4; c_in = 19'h11111;
        cyc();
        clr_sel = 4; c_sel = 3; c_in = 19'h0ABCD;
        cyc();
        a_sel = 4; b_sel = 3;
        #1;
        n_checks++;
        if ({if0.a_out, if0.b_out, if1.a_out, if1.b_out} !== {19'h0, 19'h0ABCD, 19'h0, 19'h0ABCD}) begin
            n_errors++;
            $display("FAIL clear_and_write: got %h %h %h %h want 00000 0abcd 00000 0abcd", if0.a_out, if0.b_out, if1.a_out, if1.b_out);
        end
        clear_inputs();
    endtask

    task automatic test_ignore();
        mem_op = 2'b10;
        cyc();
        mem_op = 2'b01;
        cyc();
        n_checks++;
        if ({if0.dm_rd, if0.dm_wr, if1.dm_rd, if1.dm_wr} !== 4'b1010) begin
            n_errors++;
            $display("FAIL op_while_busy: got rd/wr %b%b %b%b want 10 10", if0.dm_rd, if0.dm_wr, if1.dm_rd, if1.dm_wr);
        end
        mem_ack = 1; mem_rdata = 8'h77;
        cyc();
        mem_ack = 1; mem_rdata = 8'hEE;
        cyc();
        a_sel = 2;
        #1;
        n_checks++;
        if ({if0.busy, if0.dm_rd, if0.dm_wr, if1.busy, if1.dm_rd, if1.dm_wr} !== 6'b0) begin
            n_errors++;
            $display("FAIL ack_in_idle_flags: got %b%b%b %b%b%b want 000 000", if0.busy, if0.dm_rd, if0.dm_wr, if1.busy, if1.dm_rd, if1.dm_wr);
        end
        n_checks++;
        if ({if0.a_out, if1.a_out, if1.dm_addr} !== {19'h00077, 19'h00077, 19'h00004}) begin
            n_errors++;
            $display("FAIL ack_in_idle_regs: got %h %h dmar %h want 00077 00077 00004", if0.a_out, if1.a_out, if1.dm_addr);
        end
        mem_op = 2'b11;
        cyc();
        n_checks++;
        if ({if0.busy, if0.dm_rd, if0.dm_wr, if1.busy} !== 4'b0) begin
            n_errors++;
            $display("FAIL reserved_op: got %b%b%b %b want 000 0", if0.busy, if0.dm_rd, if0.dm_wr, if1.busy);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        mem_op = 2'b10;
        cyc();
        mem_ack = 1; mem_rdata = 8'h12;
        cyc();
        mem_op = 2'b01;
        #1;
        n_checks++;
        if ({if0.busy, if1.busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL b2b_idle_gap: got busy %b%b want 00", if0.busy, if1.busy);
        end
        cyc();
        n_checks++;
        if ({if0.dm_wr, if1.dm_wr, if0.dm_wdata, if1.dm_wdata} !== {2'b11, 8'h12, 8'h12}) begin
            n_errors++;
            $display("FAIL b2b_store: got wr %b%b wd %h %h want 11 12 12", if0.dm_wr, if1.dm_wr, if0.dm_wdata, if1.dm_wdata);
        end
        mem_ack = 1;
        cyc();
        n_checks++;
        if ({if0.busy, if1.busy, if0.dm_addr, if1.dm_addr} !== {2'b00, 19'h00100, 19'h00006}) begin
            n_errors++;
            $display("FAIL b2b_done: got busy %b%b dmar %h %h want 00 00100 00006", if0.busy, if1.busy, if0.dm_addr, if1.dm_addr);
        end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        c_sel = 1; c_in = 19'h00030;
        cyc();
        mem_op = 2'b10;
        cyc();
        n_checks++;
        if ({if0.busy, if1.busy} !== 2'b11) begin
            n_errors++;
            $display("FAIL abort_setup_busy: got %b%b want 11", if0.busy, if1.busy);
        end
        rst = 1'b1; mem_ack = 1; mem_rdata = 8'hFF;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({if0.busy, if0.dm_rd, if1.busy, if1.dm_rd} !== 4'b0) begin
            n_errors++;
            $display("FAIL abort_flags: got %b%b %b%b want 00 00", if0.busy, if0.dm_rd, if1.busy, if1.dm_rd);
        end
        n_checks++;
        if ({if0.dm_addr, if1.dm_addr, if0.dm_wdata, if1.dm_wdata} !== 54'h0) begin
            n_errors++;
            $display("FAIL abort_dm: got %h %h %h %h want 0", if0.dm_addr, if1.dm_addr, if0.dm_wdata, if1.dm_wdata);
        end
        for (int s = 1; s <= 14; s++) begin
            a_sel = 4'(s); b_sel = 4'(s);
            #1;
            n_checks++;
            if ({if0.a_out, if1.b_out} !== 38'h0) begin
                n_errors++;
                $display("FAIL abort_reg%0d: got %h %h want 0", s, if0.a_out, if1.b_out);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_read_write();
        test_load();
        test_store_wrap();
        test_priority();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
